// File: rtl/stream_merge_pkg.sv
// Shared types and constants for the two-input round-robin stream merger.
// Also provides the saturating counter helper used when STREAM_MERGE2_RR_STATS_EN is defined.
package stream_merge_pkg;

  typedef logic src_t;

  localparam src_t SRC_IN0 = 1'b0;
  localparam src_t SRC_IN1 = 1'b1;

  localparam int STATS_CNT_W = 8;

  function automatic logic [STATS_CNT_W-1:0] sat_inc(input logic [STATS_CNT_W-1:0] v);
    if (v == {STATS_CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + {{(STATS_CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. It holds the priority pointer, and the
// winner of each transfer hands priority to the other requester.
module rr_arb2
  import stream_merge_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       xfer,
  output src_t       grant
);

  src_t prio_q;
  src_t prio_d;

  // With no request, grant falls back to prio so the mux select stays defined.
  always_comb begin
    case (req)
      2'b01:   grant = SRC_IN0;
      2'b10:   grant = SRC_IN1;
      default: grant = prio_q;
    endcase
  end

  // The pointer moves only on an accepted transfer.
  always_comb begin
    prio_d = prio_q;
    if (xfer) begin
      prio_d = ~grant;
    end else begin
      prio_d = prio_q;
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio_q <= SRC_IN0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/stream_merge2_rr.sv
// Merges two val/rdy streams into one registered output stream using round-robin arbitration.
// Define STREAM_MERGE2_RR_STATS_EN to add the saturating per-input transfer counters cnt0 and cnt1.
module stream_merge2_rr
  import stream_merge_pkg::*;
#(
  parameter int p_nbits = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in0_val,
  output logic               in0_rdy,
  input  logic [p_nbits-1:0] in0_msg,
  input  logic               in1_val,
  output logic               in1_rdy,
  input  logic [p_nbits-1:0] in1_msg,
  output logic               out_val,
  input  logic               out_rdy,
  output logic [p_nbits-1:0] out_msg,
  output src_t               out_src
`ifdef STREAM_MERGE2_RR_STATS_EN
  ,
  output logic [STATS_CNT_W-1:0] cnt0,
  output logic [STATS_CNT_W-1:0] cnt1
`endif
);

  logic               out_val_q, out_val_d;
  logic [p_nbits-1:0] out_msg_q, out_msg_d;
  src_t               out_src_q, out_src_d;

  src_t               grant_s;
  logic               space_s;
  logic               acc0_s;
  logic               acc1_s;
  logic               xfer_s;
  logic [p_nbits-1:0] out_next_s;

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   ({in1_val, in0_val}),
    .xfer  (xfer_s),
    .grant (grant_s)
  );

  assign space_s = ~out_val_q | out_rdy;

  // Ready is forced low during reset so nothing is handshaken before the first edge.
  assign in0_rdy = ~reset & space_s & in0_val & (grant_s == SRC_IN0);
  assign in1_rdy = ~reset & space_s & in1_val & (grant_s == SRC_IN1);

  assign acc0_s = in0_val & in0_rdy;
  assign acc1_s = in1_val & in1_rdy;
  assign xfer_s = acc0_s | acc1_s;

  assign out_next_s = (grant_s == SRC_IN1) ? in1_msg : in0_msg;

  // Next state of the output register: refill on a transfer, otherwise drain or hold.
  always_comb begin
    out_val_d = out_val_q;
    out_msg_d = out_msg_q;
    out_src_d = out_src_q;
    if (xfer_s) begin
      out_val_d = 1'b1;
      out_msg_d = out_next_s;
      out_src_d = grant_s;
    end else if (out_rdy & out_val_q) begin
      out_val_d = 1'b0;
    end else begin
      out_val_d = out_val_q;
    end
  end

  // Output pipeline register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_val_q <= 1'b0;
      out_msg_q <= {p_nbits{1'b0}};
      out_src_q <= SRC_IN0;
    end else begin
      out_val_q <= out_val_d;
      out_msg_q <= out_msg_d;
      out_src_q <= out_src_d;
    end
  end

  assign out_val = out_val_q;
  assign out_msg = out_msg_q;
  assign out_src = out_src_q;

`ifdef STREAM_MERGE2_RR_STATS_EN
  logic [STATS_CNT_W-1:0] cnt0_q, cnt0_d;
  logic [STATS_CNT_W-1:0] cnt1_q, cnt1_d;

  // Per-input transfer counts, saturating at all ones.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (acc0_s) begin
      cnt0_d = sat_inc(cnt0_q);
    end else begin
      cnt0_d = cnt0_q;
    end
    if (acc1_s) begin
      cnt1_d = sat_inc(cnt1_q);
    end else begin
      cnt1_d = cnt1_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt0_q <= {STATS_CNT_W{1'b0}};
      cnt1_q <= {STATS_CNT_W{1'b0}};
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_stream_merge2_rr.sv
// Directed-vector bench for stream_merge2_rr with hand-computed expectations.
// Also covers the counters when STREAM_MERGE2_RR_STATS_EN is defined.
module tb_stream_merge2_rr;

  logic       clk;
  logic       reset;
  logic       in0_val;
  logic       in0_rdy;
  logic [3:0] in0_msg;
  logic       in1_val;
  logic       in1_rdy;
  logic [3:0] in1_msg;
  logic       out_val;
  logic       out_rdy;
  logic [3:0] out_msg;
  logic       out_src;
`ifdef STREAM_MERGE2_RR_STATS_EN
  logic [7:0] cnt0;
  logic [7:0] cnt1;
`endif

  int n_vec;
  int n_err;

  stream_merge2_rr #(.p_nbits(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .in0_val (in0_val),
    .in0_rdy (in0_rdy),
    .in0_msg (in0_msg),
    .in1_val (in1_val),
    .in1_rdy (in1_rdy),
    .in1_msg (in1_msg),
    .out_val (out_val),
    .out_rdy (out_rdy),
    .out_msg (out_msg),
    .out_src (out_src)
`ifdef STREAM_MERGE2_RR_STATS_EN
    ,
    .cnt0    (cnt0),
    .cnt1    (cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [3:0] msg, input logic src);
    check_eq({tag, "_val"}, {31'd0, out_val}, 32'd1);
    check_eq({tag, "_msg"}, {28'd0, out_msg}, {28'd0, msg});
    check_eq({tag, "_src"}, {31'd0, out_src}, {31'd0, src});
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    n_vec   = 0;
    n_err   = 0;
    reset   = 1'b1;
    in0_val = 1'b1;
    in0_msg = 4'h0;
    in1_val = 1'b0;
    in1_msg = 4'h0;
    out_rdy = 1'b0;
    #2;
    check_eq("rst_out_val", {31'd0, out_val}, 32'd0);
    check_eq("rst_out_msg", {28'd0, out_msg}, 32'd0);
    check_eq("rst_out_src", {31'd0, out_src}, 32'd0);
    check_eq("rst_in0_rdy", {31'd0, in0_rdy}, 32'd0);
    check_eq("rst_in1_rdy", {31'd0, in1_rdy}, 32'd0);

    @(negedge clk);
    reset   = 1'b0;
    in0_val = 1'b0;
    #1;
    check_eq("idle_in0_rdy", {31'd0, in0_rdy}, 32'd0);
    check_eq("idle_in1_rdy", {31'd0, in1_rdy}, 32'd0);
    check_eq("idle_out_val", {31'd0, out_val}, 32'd0);
    step();

    // Single stream: A then 5 from in0.
    in0_val = 1'b1;
    in0_msg = 4'hA;
    out_rdy = 1'b1;
    #1;
    check_eq("single_in0_rdy", {31'd0, in0_rdy}, 32'd1);
    check_eq("single_in1_rdy", {31'd0, in1_rdy}, 32'd0);
    step();
    in0_msg = 4'h5;
    #1;
    expect_out("single_a", 4'hA, 1'b0);
    check_eq("single_in0_rdy2", {31'd0, in0_rdy}, 32'd1);
    step();
    in0_val = 1'b0;
    #1;
    expect_out("single_5", 4'h5, 1'b0);
    step();
    check_eq("single_drain", {31'd0, out_val}, 32'd0);

    // in1 alone sends 9, leaving priority with in0.
    in1_val = 1'b1;
    in1_msg = 4'h9;
    #1;
    check_eq("p_in1_rdy", {31'd0, in1_rdy}, 32'd1);
    step();
    in1_val = 1'b0;
    #1;
    expect_out("p_9", 4'h9, 1'b1);
    step();
    check_eq("p_idle_in0_rdy", {31'd0, in0_rdy}, 32'd0);
    check_eq("p_idle_in1_rdy", {31'd0, in1_rdy}, 32'd0);
    step();
    in0_val = 1'b1;
    in0_msg = 4'h1;
    in1_val = 1'b1;
    in1_msg = 4'h2;
    #1;
    check_eq("p_both_in0_rdy", {31'd0, in0_rdy}, 32'd1);
    check_eq("p_both_in1_rdy", {31'd0, in1_rdy}, 32'd0);
    step();
    in0_val = 1'b0;
    #1;
    expect_out("p_1", 4'h1, 1'b0);
    check_eq("p_in1_rdy2", {31'd0, in1_rdy}, 32'd1);
    step();
    in1_val = 1'b0;
    #1;
    expect_out("p_2", 4'h2, 1'b1);
    step();

    // Contention: both continuously valid, output alternates.
    in0_val = 1'b1;
    in0_msg = 4'h3;
    in1_val = 1'b1;
    in1_msg = 4'hC;
    step();
    expect_out("c0", 4'h3, 1'b0);
    step();
    expect_out("c1", 4'hC, 1'b1);
    step();
    expect_out("c2", 4'h3, 1'b0);
    step();
    expect_out("c3", 4'hC, 1'b1);

    // Backpressure: load 7 from in0, then stall the consumer for 3 cycles.
    in0_msg = 4'h7;
    step();
    out_rdy = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      expect_out("bp", 4'h7, 1'b0);
      check_eq("bp_in0_rdy", {31'd0, in0_rdy}, 32'd0);
      check_eq("bp_in1_rdy", {31'd0, in1_rdy}, 32'd0);
      step();
    end
    out_rdy = 1'b1;
    #1;
    check_eq("rel_in1_rdy", {31'd0, in1_rdy}, 32'd1);
    check_eq("rel_in0_rdy", {31'd0, in0_rdy}, 32'd0);
    step();
    expect_out("rel_c", 4'hC, 1'b1);
    check_eq("rel_in0_rdy2", {31'd0, in0_rdy}, 32'd1);
    step();
    expect_out("rel_7", 4'h7, 1'b0);

    // Asynchronous reset while the output holds a message.
    #2;
    reset = 1'b1;
    #1;
    check_eq("mid_rst_val", {31'd0, out_val}, 32'd0);
    check_eq("mid_rst_msg", {28'd0, out_msg}, 32'd0);
    check_eq("mid_rst_in0_rdy", {31'd0, in0_rdy}, 32'd0);
    in0_val = 1'b0;
    in1_val = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    step();

`ifdef STREAM_MERGE2_RR_STATS_EN
    check_eq("cnt0_rst", {24'd0, cnt0}, 32'd0);
    check_eq("cnt1_rst", {24'd0, cnt1}, 32'd0);
    in0_val = 1'b1;
    in0_msg = 4'h4;
    out_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      step();
    end
    in0_val = 1'b0;
    in1_val = 1'b1;
    in1_msg = 4'hB;
    step();
    step();
    in1_val = 1'b0;
    step();
    check_eq("cnt0_sat", {24'd0, cnt0}, 32'hFF);
    check_eq("cnt1_two", {24'd0, cnt1}, 32'h02);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
